// File: rtl/pixel_fb_pkg.sv
// Shared FSM encoding and default geometry for the double-buffered pixel framebuffer.
package pixel_fb_pkg;

  typedef enum logic [1:0] {
    FB_IDLE      = 2'd0,
    FB_CLEAR     = 2'd1,
    FB_SWAP_WAIT = 2'd2
  } fb_state_e;

  localparam int FB_WIDTH      = 64;
  localparam int FB_HEIGHT     = 64;
  localparam int FB_COLOR_BITS = 3;

endpackage

// File: rtl/fb_bank.sv
// One display buffer: top/bottom half arrays, one synchronous write port and a
// registered read port returning both halves at the same word address.
module fb_bank #(
  parameter int AW = 11,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          wr_half,
  input  logic          wr_both,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_top,
  output logic [CW-1:0] rd_bot
);

  logic [CW-1:0] top_mem [2**AW];
  logic [CW-1:0] bot_mem [2**AW];
  logic [CW-1:0] rd_top_d, rd_top_q, rd_bot_d, rd_bot_q;

  // Arrays are intentionally left unreset; only the read register is.
  always_ff @(posedge clk) begin
    if (we && (wr_both || !wr_half)) top_mem[wr_addr] <= wr_data;
    if (we && (wr_both ||  wr_half)) bot_mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_top_d = top_mem[rd_addr];
    rd_bot_d = bot_mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_top_q <= '0;
      rd_bot_q <= '0;
    end else begin
      rd_top_q <= rd_top_d;
      rd_bot_q <= rd_bot_d;
    end
  end

  assign rd_top = rd_top_q;
  assign rd_bot = rd_bot_q;

endmodule

// File: rtl/pixel_framebuffer.sv
// Double-buffered framebuffer: writer draws into the back bank, the scan driver
// reads the front bank; swaps are deferred to the next frame_start.
module pixel_framebuffer
  import pixel_fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int COLOR_BITS = FB_COLOR_BITS,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int RW = YW - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [XW-1:0]         write_x,
  input  logic [YW-1:0]         write_y,
  input  logic [COLOR_BITS-1:0] write_color,
  input  logic                  clear_req,
  output logic                  clear_done,
  input  logic                  swap_req,
  output logic                  swap_done,
  input  logic                  frame_start,
  input  logic [XW-1:0]         col_addr,
  input  logic [RW-1:0]         row_addr,
  output logic [COLOR_BITS-1:0] rgb_top,
  output logic [COLOR_BITS-1:0] rgb_bot,
  output logic                  front_sel
);

  localparam int AW = XW + RW;
  localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT / 2 - 1);

  fb_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            front_q, front_d;
  logic            rd_sel_q;
  logic            clr_done_q, clr_done_d;
  logic            swp_done_q, swp_done_d;
  logic            clr_en, wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLOR_BITS-1:0] wr_data;
  logic [1:0]      bank_we;
  logic [1:0][COLOR_BITS-1:0] rd_top, rd_bot;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    front_d     = front_q;
    clr_done_d  = 1'b0;
    swp_done_d  = 1'b0;
    clr_en      = 1'b0;
    write_ready = 1'b0;
    unique case (state_q)
      FB_IDLE: begin
        write_ready = 1'b1;
        // A simultaneous swap is parked so it follows the clear.
        if (clear_req) begin
          state_d = FB_CLEAR;
          cnt_d   = '0;
          pend_d  = swap_req;
        end else if (swap_req) begin
          state_d = FB_SWAP_WAIT;
        end
      end
      FB_CLEAR: begin
        clr_en = 1'b1;
        if (swap_req) pend_d = 1'b1;
        if (cnt_q == LAST) begin
          clr_done_d = 1'b1;
          pend_d     = 1'b0;
          state_d    = (pend_q || swap_req) ? FB_SWAP_WAIT : FB_IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      FB_SWAP_WAIT: begin
        if (frame_start) begin
          front_d    = ~front_q;
          swp_done_d = 1'b1;
          state_d    = FB_IDLE;
        end
      end
      default: state_d = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FB_IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      front_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      clr_done_q <= 1'b0;
      swp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      front_q    <= front_d;
      rd_sel_q   <= front_q;  // bank that was front when the address was sampled
      clr_done_q <= clr_done_d;
      swp_done_q <= swp_done_d;
    end
  end

  assign wr_en   = write_valid && write_ready;
  assign wr_addr = clr_en ? cnt_q : {write_y[RW-1:0], write_x};
  assign wr_data = clr_en ? CLEAR_COLOR : write_color;

  always_comb begin
    bank_we[0] = (wr_en || clr_en) &&  front_q;
    bank_we[1] = (wr_en || clr_en) && !front_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank #(.AW(AW), .CW(COLOR_BITS)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (bank_we[b]),
      .wr_half (write_y[YW-1]),
      .wr_both (clr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr ({row_addr, col_addr}),
      .rd_top  (rd_top[b]),
      .rd_bot  (rd_bot[b])
    );
  end

  assign rgb_top    = rd_top[rd_sel_q];
  assign rgb_bot    = rd_bot[rd_sel_q];
  assign front_sel  = front_q;
  assign clear_done = clr_done_q;
  assign swap_done  = swp_done_q;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Randomized bench for pixel_framebuffer against a two-buffer pixel array model.
module tb_pixel_framebuffer;

  localparam int W = 64, H = 64, CB = 3;
  localparam int XW = 6, YW = 6, RW = 5;
  localparam int HALF = W * H / 2;
  localparam logic [CB-1:0] CC = 3'b001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic write_valid = 1'b0, write_ready;
  logic [XW-1:0] write_x = '0;
  logic [YW-1:0] write_y = '0;
  logic [CB-1:0] write_color = '0;
  logic clear_req = 1'b0, clear_done, swap_req = 1'b0, swap_done, frame_start = 1'b0;
  logic [XW-1:0] col_addr = '0;
  logic [RW-1:0] row_addr = '0;
  logic [CB-1:0] rgb_top, rgb_bot;
  logic front_sel;

  always #5 clk = ~clk;

  pixel_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst_n(rst_n), .write_valid(write_valid), .write_ready(write_ready),
    .write_x(write_x), .write_y(write_y), .write_color(write_color),
    .clear_req(clear_req), .clear_done(clear_done), .swap_req(swap_req),
    .swap_done(swap_done), .frame_start(frame_start), .col_addr(col_addr),
    .row_addr(row_addr), .rgb_top(rgb_top), .rgb_bot(rgb_bot), .front_sel(front_sel)
  );

  int n_vec = 0, n_err = 0;
  logic [CB-1:0] ref_mem [2][H][W];
  int ref_front = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input int x, input int r);
    col_addr = XW'(x);
    row_addr = RW'(r);
    step();
    chk("rgb_top", 32'(rgb_top), 32'(ref_mem[ref_front][r][x]));
    chk("rgb_bot", 32'(rgb_bot), 32'(ref_mem[ref_front][r + H/2][x]));
  endtask

  task automatic do_write(input int x, input int y, input int c);
    write_x = XW'(x); write_y = YW'(y); write_color = CB'(c);
    write_valid = 1'b1;
    chk("write_ready", 32'(write_ready), 32'd1);
    step();
    write_valid = 1'b0;
    ref_mem[1 - ref_front][y][x] = CB'(c);
  endtask

  // Waits in SWAP_WAIT with a writer trying to sneak a pixel in, then frames.
  task automatic finish_swap();
    int gx, gy, idle;
    gx = $urandom_range(0, W-1); gy = $urandom_range(0, H-1);
    idle = $urandom_range(0, 3);
    write_x = XW'(gx); write_y = YW'(gy); write_color = CB'($urandom);
    write_valid = 1'b1;
    for (int i = 0; i < idle; i++) begin
      chk("wait_ready", 32'(write_ready), 32'd0);
      step();
      chk("wait_no_swap", 32'(swap_done), 32'd0);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0; write_valid = 1'b0;
    ref_front = 1 - ref_front;
    chk("swap_done", 32'(swap_done), 32'd1);
    chk("front_sel", 32'(front_sel), 32'(ref_front));
    read_chk(gx, gy % (H/2));
    chk("swap_done_pulse", 32'(swap_done), 32'd0);
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    frame_start = 1'($urandom_range(0, 1));
    step();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("swap_early", 32'(swap_done), 32'd0);
    chk("swap_ready", 32'(write_ready), 32'd0);
    finish_swap();
  endtask

  // mode 0: plain, 1: swap with clear_req, 2: swap mid-clear; fs_at pulses frame_start.
  task automatic do_clear(input int mode, input int fs_at);
    int n, bad, sw;
    clear_req = 1'b1; swap_req = (mode == 1);
    step();
    clear_req = 1'b0; swap_req = 1'b0;
    n = 0; bad = 0; sw = 0;
    while (!clear_done && n < HALF + 100) begin
      if (write_ready) bad++;
      if (swap_done) sw++;
      if (n == fs_at) frame_start = 1'b1;
      if (n == 7) clear_req = 1'b1;
      if (n == 9 && mode == 2) swap_req = 1'b1;
      step();
      frame_start = 1'b0; clear_req = 1'b0; swap_req = 1'b0;
      n++;
    end
    chk("clear_len", 32'(n), 32'(HALF));
    chk("clear_busy", 32'(bad), 32'd0);
    chk("clear_no_swap", 32'(sw), 32'd0);
    chk("clear_front", 32'(front_sel), 32'(ref_front));
    chk("clear_post_ready", 32'(write_ready), (mode != 0) ? 32'd0 : 32'd1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) ref_mem[1 - ref_front][y][x] = CC;
    step();
    chk("clear_done_pulse", 32'(clear_done), 32'd0);
    if (mode != 0) finish_swap();
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_top", 32'(rgb_top), 32'd0);
    chk("rst_bot", 32'(rgb_bot), 32'd0);
    chk("rst_cdone", 32'(clear_done), 32'd0);
    chk("rst_sdone", 32'(swap_done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(write_ready), 32'd1);
    chk("rst_front2", 32'(front_sel), 32'd0);

    // Initialise both banks: clear back, swap, then clear+swap together.
    do_clear(0, -1);
    do_swap();
    do_clear(1, 500);
    for (int r = 0; r < H/2; r++)
      for (int x = 0; x < W; x++) read_chk(x, r);

    // Write-and-swap plus isolation of the displayed buffer.
    do_write(5, 3, 3'b101);
    do_write(5, 35, 3'b010);
    do_write(0, 0, 7);
    read_chk(5, 3);
    read_chk(0, 0);
    do_swap();
    read_chk(5, 3);
    read_chk(0, 0);

    repeat (300) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: do_write($urandom_range(0, W-1), $urandom_range(0, H-1), $urandom_range(0, 7));
        6, 7, 8:          read_chk($urandom_range(0, W-1), $urandom_range(0, H/2-1));
        default:          do_swap();
      endcase
    end

    do_clear(2, -1);
    repeat (20) read_chk($urandom_range(0, W-1), $urandom_range(0, H/2-1));

    // Reset in the middle of a clear that has a swap pending.
    if (ref_front == 0) do_swap();
    clear_req = 1'b1; swap_req = 1'b1;
    step();
    clear_req = 1'b0; swap_req = 1'b0;
    repeat (100) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_front", 32'(front_sel), 32'd0);
    chk("midrst_top", 32'(rgb_top), 32'd0);
    chk("midrst_ready", 32'(write_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_ready2", 32'(write_ready), 32'd1);
    seen = 0;
    for (int n = 0; n < HALF + 50; n++) begin
      if (clear_done || swap_done) seen++;
      if (n == 300) frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    chk("midrst_no_pulse", 32'(seen), 32'd0);
    chk("midrst_front2", 32'(front_sel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Parametrised, double-buffered pixel framebuffer between the physics/render writer and the HUB75 scan driver. The writer draws into a back buffer through a valid/ready port. The display reads top-half and bottom-half pixels from the front buffer with fixed one-cycle latency. Buffer swap is synchronised to the driver's frame boundary, and a hardware clear fills the back buffer without writer involvement.

## Interface
- `WIDTH`, 64, panel columns; power of two.
- `HEIGHT`, 64, panel rows; power of two, ≥2.
- `COLOR_BITS`, 3, bits per pixel.
- `CLEAR_COLOR`, 0, `COLOR_BITS`-wide fill value used by clear.
- Derived: `XW=$clog2(WIDTH)`, `YW=$clog2(HEIGHT)`, `RW=YW-1`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `write_valid` in 1: writer presents a pixel.
- `write_ready` out 1: block accepts the pixel this cycle.
- `write_x` in XW: column.
- `write_y` in YW: row; MSB selects the half (1 = bottom).
- `write_color` in COLOR_BITS: pixel value.
- `clear_req` in 1: pulse; fill the back buffer with `CLEAR_COLOR`.
- `clear_done` out 1: one-cycle pulse when the fill completes.
- `swap_req` in 1: pulse; make the back buffer the front buffer at the next frame boundary.
- `swap_done` out 1: one-cycle pulse on the cycle the swap takes effect.
- `frame_start` in 1: pulse from the scan driver at the start of each display frame.
- `col_addr` in XW: display column.
- `row_addr` in RW: display row within a half.
- `rgb_top` out COLOR_BITS: pixel (`row_addr`, `col_addr`).
- `rgb_bot` out COLOR_BITS: pixel (`row_addr+HEIGHT/2`, `col_addr`).
- `front_sel` out 1: index of the buffer currently displayed.

## Operation
- Two buffers, each split into a top half and a bottom half of `WIDTH*HEIGHT/2` words. Word address = `{y[RW-1:0], x}`.
- Writes go only to buffer `~front_sel`. Reads come only from buffer `front_sel`. Reads and writes never contend.
- FSM states:
  - **IDLE**: `write_ready=1`.
    - `clear_req` → CLEAR.
    - Else `swap_req` → SWAP_WAIT.
    - If `clear_req` and `swap_req` arrive in the same cycle: clear runs first, and the swap is latched as pending.
  - **CLEAR**: `write_ready=0`.
    - A counter runs 0..`WIDTH*HEIGHT/2-1` and writes `CLEAR_COLOR` to both halves of the back buffer at the counter address, one word per cycle.
    - After the last word: pulse `clear_done`. Go to SWAP_WAIT if a swap is pending, else IDLE.
    - `swap_req` during CLEAR sets pending. `clear_req` during CLEAR is ignored.
  - **SWAP_WAIT**: `write_ready=0`, so the writer cannot modify the buffer about to be displayed.
    - On `frame_start`: toggle `front_sel`, pulse `swap_done`, go to IDLE.
    - `clear_req` and `swap_req` are ignored in this state.
- `swap_req` and `frame_start` in the same IDLE cycle: go to SWAP_WAIT only; the swap waits for the next `frame_start`.
- A write is accepted when `write_valid && write_ready`. A write accepted in the same cycle as `clear_req` is committed, then overwritten by the clear.
- Memory contents are not reset. Software issues a clear before the first swap.

## Timing
- Reset values: state IDLE, `front_sel=0`, `rgb_top=rgb_bot=0`, `clear_done=swap_done=0`, pending cleared. `write_ready=1` from the first cycle after deassertion.
- Read latency is 1 cycle: address sampled at edge N, data valid after edge N+1. Data comes from the buffer that was front at edge N.
- Write latency is 1 cycle: a read of the same pixel issued after the swap returns the new value.
- Clear takes exactly `WIDTH*HEIGHT/2` cycles. `clear_done` is asserted in the cycle after the last word is written.
- `swap_done` is asserted on the edge following `frame_start`, coincident with the new `front_sel` value.
- Reset asserted mid-CLEAR or mid-SWAP_WAIT aborts immediately. The clear stays partial, `front_sel` returns to 0, and pending is dropped.

## Structure
- Package `pixel_fb_pkg`: FSM state enum (`FB_IDLE`, `FB_CLEAR`, `FB_SWAP_WAIT`) and shared default parameter constants.
- One sub-module, `fb_bank`: one buffer with top and bottom half arrays, a synchronous write port (address, half select, both-halves enable for clear), and a synchronous read port returning both halves. It is instantiated twice.
- Top level holds the FSM, clear counter, swap pending flag, bank steering, and output muxing.

## Test plan
- **Reset**: after `rst_n` release → `front_sel=0`, `write_ready=1`, `rgb_top=rgb_bot=0`.
- **Write and swap**:
  - Stimulus: write (5,3)=3'b101 and (5,35)=3'b010, then `swap_req`, then `frame_start`.
  - `swap_done` is asserted one cycle after `frame_start`, with `front_sel=1`.
  - Reading `col=5`, `row=3` → `rgb_top=101`, `rgb_bot=010` one cycle later.
- **Clear**: `clear_req` with `CLEAR_COLOR=3'b001`:
  - `write_ready=0` for 2048 cycles, then `clear_done` is pulsed.
  - After a swap, every address reads 001 on both halves.
- **Write isolation**: while displaying buffer 0, write (0,0)=7 → the front read at (0,0) is unchanged until after the swap.
- **Simultaneous requests**: `clear_req` and `swap_req` in the same cycle → clear runs fully, then SWAP_WAIT. A `frame_start` during the clear does not swap; the first `frame_start` after `clear_done` does.
- **Reset mid-clear**: assert `rst_n=0` at clear cycle 100 → FSM is IDLE, pending is cleared, and no `clear_done` pulse occurs after release.
